// File: rtl/config_loader.sv
// config_loader: clears the grid configuration chain, then serialises a byte
// stream into it LSB first, checking the bits that come back out of the chain.
module config_loader #(
  parameter int unsigned CHAIN_LENGTH = 4096,
  parameter int unsigned CLEAR_CYCLES = 4
) (
  input  logic       clock,
  input  logic       nreset,
  input  logic       start,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic       cfg_data,
  output logic       cfg_enable,
  output logic       cfg_nreset,
  input  logic       cfg_return,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned CW = $clog2(CHAIN_LENGTH + 1);
  localparam int unsigned KW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t        state, state_d;
  logic [KW-1:0] clr_cnt, clr_cnt_d;
  logic [7:0]    shift_buf, shift_buf_d;
  logic [3:0]    occ, occ_d;
  logic [CW-1:0] bits_sent, bits_sent_d;
  logic [CW-1:0] bits_acc, bits_acc_d;
  logic          cfg_data_d, cfg_enable_d, cfg_nreset_d;
  logic          busy_d, done_d, error_d;
  logic          sending;
  logic [31:0]   rem_c;
  logic [3:0]    occ_load;

  // Bits still owed to the chain decide how much of the next byte is kept.
  always_comb begin
    rem_c    = 32'(CHAIN_LENGTH) - 32'(bits_acc);
    occ_load = (rem_c >= 32'd8) ? 4'd8 : 4'(rem_c);
  end

  // A byte can be taken when the buffer is empty or its last bit leaves now.
  assign s_ready = (state == SHIFT) && (occ <= 4'd1) &&
                   (bits_acc < CW'(CHAIN_LENGTH));

  assign sending = (occ != 4'd0);

  // Next-state and next-output logic for the load sequence.
  always_comb begin
    state_d      = state;
    clr_cnt_d    = clr_cnt;
    shift_buf_d  = shift_buf;
    occ_d        = occ;
    bits_sent_d  = bits_sent;
    bits_acc_d   = bits_acc;
    cfg_data_d   = 1'b0;
    cfg_enable_d = 1'b0;
    cfg_nreset_d = cfg_nreset;
    busy_d       = busy;
    done_d       = done;
    error_d      = error;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_d      = CLEAR;
          clr_cnt_d    = '0;
          bits_sent_d  = '0;
          bits_acc_d   = '0;
          occ_d        = 4'd0;
          cfg_nreset_d = 1'b0;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          error_d      = 1'b0;
        end
      end

      CLEAR: begin
        cfg_nreset_d = 1'b0;
        clr_cnt_d    = clr_cnt + KW'(1);
        if (clr_cnt == KW'(CLEAR_CYCLES - 1)) begin
          state_d      = SHIFT;
          cfg_nreset_d = 1'b1;
        end
      end

      SHIFT: begin
        // The bit on cfg_data goes into the chain at this edge.
        if (sending) begin
          shift_buf_d = {1'b0, shift_buf[7:1]};
          occ_d       = occ - 4'd1;
          bits_sent_d = bits_sent + CW'(1);
          if (cfg_return) error_d = 1'b1;
        end
        if (s_valid && s_ready) begin
          shift_buf_d = s_data;
          occ_d       = occ_load;
          bits_acc_d  = bits_acc + CW'(occ_load);
        end
        if (sending && (bits_sent == CW'(CHAIN_LENGTH - 1))) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (occ_d != 4'd0) begin
          cfg_enable_d = 1'b1;
          cfg_data_d   = shift_buf_d[0];
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state      <= IDLE;
      clr_cnt    <= '0;
      shift_buf  <= 8'd0;
      occ        <= 4'd0;
      bits_sent  <= '0;
      bits_acc   <= '0;
      cfg_data   <= 1'b0;
      cfg_enable <= 1'b0;
      cfg_nreset <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_d;
      clr_cnt    <= clr_cnt_d;
      shift_buf  <= shift_buf_d;
      occ        <= occ_d;
      bits_sent  <= bits_sent_d;
      bits_acc   <= bits_acc_d;
      cfg_data   <= cfg_data_d;
      cfg_enable <= cfg_enable_d;
      cfg_nreset <= cfg_nreset_d;
      busy       <= busy_d;
      done       <= done_d;
      error      <= error_d;
    end
  end

endmodule

// File: tb/tb_config_loader.sv
// Bench for config_loader: a 16-bit chain instance and a 12-bit chain instance.
module tb_config_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic nreset;

  logic       a_start, a_svalid, a_sready, a_data, a_en, a_nrst, a_ret, a_busy, a_done, a_err;
  logic [7:0] a_sdata;
  logic       b_start, b_svalid, b_sready, b_data, b_en, b_nrst, b_ret, b_busy, b_done, b_err;
  logic [7:0] b_sdata;

  config_loader #(.CHAIN_LENGTH(16), .CLEAR_CYCLES(4)) dut_a (
    .clock(clk), .nreset(nreset), .start(a_start), .s_data(a_sdata), .s_valid(a_svalid),
    .s_ready(a_sready), .cfg_data(a_data), .cfg_enable(a_en), .cfg_nreset(a_nrst),
    .cfg_return(a_ret), .busy(a_busy), .done(a_done), .error(a_err)
  );

  config_loader #(.CHAIN_LENGTH(12), .CLEAR_CYCLES(4)) dut_b (
    .clock(clk), .nreset(nreset), .start(b_start), .s_data(b_sdata), .s_valid(b_svalid),
    .s_ready(b_sready), .cfg_data(b_data), .cfg_enable(b_en), .cfg_nreset(b_nrst),
    .cfg_return(b_ret), .busy(b_busy), .done(b_done), .error(b_err)
  );

  int total = 0;
  int bad   = 0;

  // Hand-derived bit order for 0xA5 then 0x3C, LSB first.
  logic exp_a [16] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                       1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  logic q_a [$];
  logic q_b [$];
  int   en_a = 0, nr_a = 0, en_b = 0;
  int   en_base_a = 0, nr_base_a = 0, en_base_b = 0;
  bit   fault_on = 1'b0;

  assign a_ret = fault_on && a_en && ((en_a - en_base_a) == 5);
  assign b_ret = 1'b0;

  function automatic void chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  // Monitor for the 16-bit instance: pops one expected bit per enabled cycle.
  always @(negedge clk) begin
    if (nreset) begin
      if (!a_nrst) nr_a++;
      if (a_en) begin
        en_a++;
        if (q_a.size() == 0) chk("a_extra_bit", 1, 0);
        else chk("a_bit", int'(a_data), int'(q_a.pop_front()));
        if (fault_on && (en_a - en_base_a) == 5) chk("a_err_before_fault", int'(a_err), 0);
        if (fault_on && (en_a - en_base_a) == 6) chk("a_err_after_fault", int'(a_err), 1);
      end
    end
  end

  // Monitor for the 12-bit instance.
  always @(negedge clk) begin
    if (nreset && b_en) begin
      en_b++;
      if (q_b.size() == 0) chk("b_extra_bit", 1, 0);
      else chk("b_bit", int'(b_data), int'(q_b.pop_front()));
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic run_a(input logic [7:0] b0, input logic [7:0] b1, input int gap,
                       input bit pulse, input int exp_err);
    int k;
    logic [7:0] bytes [2];
    bytes[0] = b0;
    bytes[1] = b1;
    en_base_a = en_a;
    nr_base_a = nr_a;
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    chk("a_clear_nreset", int'(a_nrst), 0);
    chk("a_clear_busy", int'(a_busy), 1);
    chk("a_clear_done", int'(a_done), 0);
    chk("a_clear_error", int'(a_err), 0);
    for (int i = 0; i < 2; i++) begin
      if (i > 0 && gap > 0) begin
        k = 0;
        while (!a_sready && k < 50) begin step(); k++; end
        step();
        for (int g = 0; g < gap; g++) begin
          chk("a_gap_enable", int'(a_en), 0);
          step();
        end
      end
      a_svalid = 1'b1;
      a_sdata  = bytes[i];
      for (int j = 0; j < 8; j++) q_a.push_back(exp_a[i*8 + j]);
      k = 0;
      while (!a_sready && k < 50) begin
        a_start = pulse && ((i == 0 && k == 1) || (i == 1 && k == 2));
        step();
        k++;
      end
      a_start = 1'b0;
      if (!a_sready) chk("a_ready_timeout", 0, 1);
      if (i == 0) chk("a_ready_latency", k, 4);
      step();
      a_svalid = 1'b0;
    end
    k = 0;
    while (!a_done && k < 50) begin step(); k++; end
    chk("a_done", int'(a_done), 1);
    chk("a_busy_end", int'(a_busy), 0);
    chk("a_enable_end", int'(a_en), 0);
    chk("a_error_end", int'(a_err), exp_err);
    chk("a_enable_count", en_a - en_base_a, 16);
    chk("a_nreset_count", nr_a - nr_base_a, 4);
    chk("a_bits_left", q_a.size(), 0);
  endtask

  initial begin
    int k;
    nreset   = 1'b0;
    a_start  = 1'b0; a_svalid = 1'b0; a_sdata = 8'd0;
    b_start  = 1'b0; b_svalid = 1'b0; b_sdata = 8'd0;
    step();
    chk("rst_cfg_nreset", int'(a_nrst), 1);
    chk("rst_cfg_enable", int'(a_en), 0);
    chk("rst_cfg_data", int'(a_data), 0);
    chk("rst_busy", int'(a_busy), 0);
    chk("rst_done", int'(a_done), 0);
    chk("rst_error", int'(a_err), 0);
    chk("rst_s_ready", int'(a_sready), 0);
    nreset = 1'b1;
    step();
    step();

    // Basic load, back-to-back bytes.
    run_a(8'hA5, 8'h3C, 0, 1'b0, 0);
    // Source stalls between bytes.
    run_a(8'hA5, 8'h3C, 3, 1'b0, 0);
    // Return fault on the fifth enabled cycle.
    fault_on = 1'b1;
    run_a(8'hA5, 8'h3C, 0, 1'b0, 1);
    fault_on = 1'b0;
    // New start clears the error.
    run_a(8'hA5, 8'h3C, 0, 1'b0, 0);

    // Reset after seven bits have gone out.
    en_base_a = en_a;
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    a_svalid = 1'b1;
    a_sdata  = 8'hA5;
    for (int j = 0; j < 8; j++) q_a.push_back(exp_a[j]);
    k = 0;
    while (!a_sready && k < 50) begin step(); k++; end
    step();
    a_svalid = 1'b0;
    k = 0;
    while ((en_a - en_base_a) < 7 && k < 50) begin step(); k++; end
    chk("mid_bits_before_reset", en_a - en_base_a, 7);
    #2 nreset = 1'b0;
    #1;
    chk("mid_rst_cfg_nreset", int'(a_nrst), 1);
    chk("mid_rst_cfg_enable", int'(a_en), 0);
    chk("mid_rst_cfg_data", int'(a_data), 0);
    chk("mid_rst_busy", int'(a_busy), 0);
    chk("mid_rst_done", int'(a_done), 0);
    chk("mid_rst_error", int'(a_err), 0);
    chk("mid_rst_s_ready", int'(a_sready), 0);
    q_a.delete();
    step();
    nreset = 1'b1;
    step();
    run_a(8'hA5, 8'h3C, 0, 1'b0, 0);

    // Start pulses during CLEAR and SHIFT are ignored.
    run_a(8'hA5, 8'h3C, 0, 1'b1, 0);

    // Partial final byte on the 12-bit chain.
    en_base_b = en_b;
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      b_svalid = 1'b1;
      b_sdata  = (i == 0) ? 8'hFF : 8'h0F;
      for (int j = 0; j < ((i == 0) ? 8 : 4); j++) q_b.push_back(1'b1);
      k = 0;
      while (!b_sready && k < 50) begin step(); k++; end
      if (!b_sready) chk("b_ready_timeout", 0, 1);
      step();
    end
    b_sdata = 8'hAA;
    for (int c = 0; c < 20; c++) begin
      chk("b_ready_after_last", int'(b_sready), 0);
      step();
    end
    b_svalid = 1'b0;
    k = 0;
    while (!b_done && k < 50) begin step(); k++; end
    chk("b_done", int'(b_done), 1);
    chk("b_error", int'(b_err), 0);
    chk("b_enable_count", en_b - en_base_b, 12);
    chk("b_bits_left", q_b.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
